zigbee_freq_discriminator: RTL
==============================

# zigbee_freq_discriminator

Converts the per-sample phase word from the CORDIC stage into instantaneous frequency and integrate-and-dump chip decisions for the O-QPSK/MSK demodulator. It sits directly downstream of the CORDIC and upstream of the chip-to-symbol correlator. It differentiates phase modulo 2π and sums OSR frequency samples per chip. Each chip produces a hard chip bit plus a soft accumulator value.

## Interface
- W_SIZE, 6: phase word width; phase is two's complement, -2^(W_SIZE-1) = -180°.
- OSR, 4: samples per chip, ≥2, power of two.
- ACC_SIZE, W_SIZE+$clog2(OSR): soft chip width.
- clk  in  1  sole clock.
- nrst  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable; low flushes state.
- Win  in  W_SIZE  phase sample, signed.
- win_valid  in  1  Win qualifier, single-cycle strobes, arbitrary gaps.
- chip_align  in  1  single-cycle pulse; restarts chip integration.
- freq_o  out  W_SIZE  phase difference, signed.
- freq_valid  out  1  freq_o qualifier.
- acc_o  out  ACC_SIZE  chip integral, signed.
- chip_o  out  1  hard chip decision.
- chip_valid  out  1  chip_o/acc_o qualifier.

## Operation
- States:
  - IDLE: no previous phase held.
  - RUN: previous phase held.
- IDLE→RUN: on first win_valid with enable=1. Win is stored as prev. No freq_valid is produced for that sample.
- In RUN, on each win_valid:
  - freq = Win − prev, truncated to W_SIZE bits (natural modulo-2π wrap).
  - prev ← Win.
  - Example: Win 31 after −32 gives freq = −1 (not 63). Win −32 after 31 gives freq = 1.
  - A difference of exactly 180° maps to −2^(W_SIZE-1).
- Integrator: a sample counter cnt (0..OSR−1) and accumulator acc (ACC_SIZE bits, sign-extended adds, no saturation needed).
  - On each freq_valid: acc ← (cnt==0 ? freq : acc+freq), and cnt increments.
  - When the OSR-th sample is added: chip_valid pulses, acc_o = final sum, chip_o = 1 iff sum ≥ 0, cnt ← 0.
- chip_align:
  - Clears cnt, so the next freq sample starts a new chip. A partial chip is discarded and produces no chip_valid.
  - If chip_align coincides with freq_valid, that freq sample is sample 0 of the new chip.
  - chip_align does not affect prev or the state.
- enable=0: state → IDLE, cnt ← 0. Valids are forced low on the next cycle. Any in-flight sample is dropped.
- win_valid while enable=0 is ignored.

## Timing
- Reset values: state IDLE, prev 0, cnt 0, acc 0. Outputs: freq_o 0, freq_valid 0, acc_o 0, chip_o 0, chip_valid 0.
- Latency:
  - win_valid at cycle n → freq_valid at n+1.
  - The OSR-th freq_valid at cycle m → chip_valid at m+1.
  - Total latency from the last Win of a chip: 2 cycles.
- All valids are single-cycle pulses.
- freq_o, acc_o and chip_o hold their last value between pulses.
- Back-to-back win_valid is supported at full rate with no stall; there is no backpressure.
- Asynchronous reset mid-chip clears everything immediately. The first sample after reset is priming only.
- enable low for one cycle produces the same flush as reset, but synchronously.

## Structure
- Package zigbee_demod_pkg contains:
  - State enum typedef {IDLE, RUN}.
  - Localparam for the default OSR.
  - A function for the signed sign-extension to ACC_SIZE.
- Sub-module zigbee_phase_diff contains prev register, modulo subtraction, freq_o/freq_valid register and IDLE/RUN state.
- Top contains the integrator, counter, align logic and chip register.

## Test plan
- Reset values:
  - Stimulus: assert nrst=0 mid-stream, then release.
  - Response: all outputs 0 immediately. The first Win after release yields no freq_valid. The second Win yields freq_valid.
- Wrap:
  - Stimulus: W_SIZE=6, Win sequence 28, 31, −32, −29.
  - Response: freq_o = 3, 1, 3, each one cycle after its strobe.
- Constant positive frequency:
  - Stimulus: Win steps of +4 (0, 4, 8, … wrapping), OSR=4, continuous strobes.
  - Response: after priming, chip_valid every 4 freq samples, acc_o = 16, chip_o = 1.
  - Stimulus: the same sequence with steps of −4.
  - Response: acc_o = −16, chip_o = 0.
- Alignment:
  - Stimulus: chip_align pulse after 2 freq samples of a chip.
  - Response: no chip_valid for the partial chip. The next chip_valid follows 4 further samples, with the sum of those 4 samples.
  - Stimulus: chip_align coincident with a freq_valid.
  - Response: that sample is counted as sample 0 of the new chip.
- Gaps and zero:
  - Stimulus: strobes with random 0–5 cycle gaps.
  - Response: results identical to the continuous case.
  - Stimulus: freq samples that sum to exactly 0.
  - Response: chip_o = 1.
- Enable drop:
  - Stimulus: enable=0 for one cycle mid-chip.
  - Response: no chip_valid from the partial chip. The next Win re-primes. The counter restarts at 0.

Source files
------------

// File: rtl/zigbee_demod_pkg.sv
// Shared types and helpers for the O-QPSK/MSK frequency discriminator.
package zigbee_demod_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fd_state_e;

  localparam int DEFAULT_OSR = 4;

  // Sign-extend the low w bits of v to the full 32-bit word; callers cast down to ACC_SIZE.
  function automatic logic [31:0] sext_acc(input logic [31:0] v, input int w);
    logic signed [31:0] t;
    t = signed'(v << (32 - w));
    return 32'(t >>> (32 - w));
  endfunction

endpackage

// File: rtl/zigbee_phase_diff.sv
// Phase differentiator: holds the previous phase and emits the modulo-2pi difference.
module zigbee_phase_diff
  import zigbee_demod_pkg::*;
#(
  parameter int W_SIZE = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic [W_SIZE-1:0] win,
  input  logic              win_valid,
  output logic [W_SIZE-1:0] freq_o,
  output logic              freq_valid,
  output logic              state_o
);

  fd_state_e         state_q, state_d;
  logic [W_SIZE-1:0] prev_q, prev_d;
  logic [W_SIZE-1:0] freq_q, freq_d;
  logic              fvalid_q, fvalid_d;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    freq_d   = freq_q;
    fvalid_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      prev_d  = '0;
      freq_d  = '0;
    end else if (win_valid) begin
      prev_d  = win;
      state_d = RUN;
      // Truncating subtraction gives the natural wrap; +180 deg lands on the most negative code.
      if (state_q == RUN) begin
        freq_d   = win - prev_q;
        fvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      freq_q   <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      freq_q   <= freq_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign freq_o     = freq_q;
  assign freq_valid = fvalid_q;
  assign state_o    = state_q;

endmodule

// File: rtl/zigbee_freq_discriminator.sv
// Frequency discriminator with integrate-and-dump chip decisions over OSR samples.
// Valids are single-cycle strobes with no backpressure: data is consumed on the cycle its valid is high.
module zigbee_freq_discriminator
  import zigbee_demod_pkg::*;
#(
  parameter int W_SIZE   = 6,
  parameter int OSR      = DEFAULT_OSR,
  parameter int ACC_SIZE = W_SIZE + $clog2(OSR)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                enable,
  input  logic [W_SIZE-1:0]   Win,
  input  logic                win_valid,
  input  logic                chip_align,
  output logic [W_SIZE-1:0]   freq_o,
  output logic                freq_valid,
  output logic [ACC_SIZE-1:0] acc_o,
  output logic                chip_o,
  output logic                chip_valid,
  output logic                state_o
);

  localparam int CNT_W = $clog2(OSR);

  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_eff;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [ACC_SIZE-1:0] acc_out_q, acc_out_d;
  logic                chip_q, chip_d;
  logic                cvalid_q, cvalid_d;
  logic [ACC_SIZE-1:0] freq_ext;
  logic [ACC_SIZE-1:0] sum;

  zigbee_phase_diff #(.W_SIZE(W_SIZE)) u_phase_diff (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .win        (Win),
    .win_valid  (win_valid),
    .freq_o     (freq_o),
    .freq_valid (freq_valid),
    .state_o    (state_o)
  );

  assign freq_ext = ACC_SIZE'(sext_acc(32'(freq_o), W_SIZE));
  // An align pulse coinciding with a sample makes that sample the first of the new chip.
  assign cnt_eff  = chip_align ? '0 : cnt_q;
  assign sum      = (cnt_eff == '0) ? freq_ext : acc_q + freq_ext;

  always_comb begin
    cnt_d     = cnt_eff;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    chip_d    = chip_q;
    cvalid_d  = 1'b0;
    if (!enable) begin
      cnt_d     = '0;
      acc_d     = '0;
      acc_out_d = '0;
      chip_d    = 1'b0;
    end else if (freq_valid) begin
      acc_d = sum;
      if (cnt_eff == CNT_W'(OSR - 1)) begin
        cnt_d     = '0;
        cvalid_d  = 1'b1;
        acc_out_d = sum;
        chip_d    = ~sum[ACC_SIZE-1];
      end else begin
        cnt_d = cnt_eff + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      chip_q    <= 1'b0;
      cvalid_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      chip_q    <= chip_d;
      cvalid_q  <= cvalid_d;
    end
  end

  assign acc_o      = acc_out_q;
  assign chip_o     = chip_q;
  assign chip_valid = cvalid_q;

endmodule
